regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the DFF-based register bank among NREQ requesters, such as ALU writeback, load unit and debug.
- Arbitration is round-robin (or fixed priority), with per-requester valid/ready handshakes and optional locked bursts.
- The write-side outputs are registered and drive the bank's D inputs and write-enable directly.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 3, register address width (2^AW registers)
DW, 8, register data width
MAXBURST, 4, max consecutive locked grants to one requester before forced release (1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req_valid  input  NREQ  per-requester write request
req_lock  input  NREQ  requester asks to keep grant next cycle (burst)
req_addr  input  NREQ*AW  packed target register addresses; requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed write data; requester i at [i*DW +: DW]
req_ready  output  NREQ  accept strobe, combinational, at most one bit set
prio_fixed  input  1  1 = fixed priority (lowest index wins), 0 = round-robin
bank_stall  input  1  bank unavailable this cycle; no acceptance
wr_en  output  1  registered bank write enable
wr_addr  output  AW  registered bank write address
wr_data  output  DW  registered bank write data
grant_id  output  3  registered index of last accepted requester
locked  output  1  registered, 1 while in LOCKED state

Behaviour:
- Reset (rst_n=0 at a clk edge): wr_en=0, wr_addr=0, wr_data=0, grant_id=0, locked=0, rr_ptr=0, burst_cnt=0, state=IDLE. Reset overrides every other input, including mid-burst. req_ready is forced to 0 while rst_n=0.
- Transfer: occurs on requester i when req_valid[i] & req_ready[i] are both high at a rising edge.
- Latency: exactly 1 cycle. In the cycle after a transfer, wr_en=1 and wr_addr/wr_data/grant_id hold the captured values. With no transfer, wr_en=0 next cycle and wr_addr/wr_data/grant_id hold their old values.
- req_ready is all-zero whenever bank_stall=1 or no req_valid is set.
- IDLE state:
  - Winner is the first valid index searching upward from rr_ptr with wrap (round-robin), or the lowest valid index (prio_fixed=1).
  - req_ready[winner]=1.
  - On a transfer in round-robin mode, rr_ptr <= (winner+1) mod NREQ. In fixed mode, rr_ptr is unchanged.
  - If req_lock[winner]=1 at the transfer: go to LOCKED, owner<=winner, burst_cnt<=1, locked<=1.
- LOCKED state:
  - Only the owner may be granted: req_ready[owner] = req_valid[owner] & !bank_stall. All other readies are 0.
  - Each owner transfer increments burst_cnt.
  - Return to IDLE (locked<=0, burst_cnt<=0) on any of:
    - owner transfer with req_lock[owner]=0;
    - owner transfer that makes burst_cnt reach MAXBURST;
    - a cycle with req_valid[owner]=0 and bank_stall=0.
  - bank_stall in LOCKED: state held, burst_cnt held.
  - After a forced release, in round-robin mode rr_ptr = owner+1, so the owner cannot immediately win again if another requester is valid.
- Simultaneous events:
  - Stall plus valid requests: nothing is accepted, rr_ptr is held, wr_en=0 next cycle.
  - Duplicate addresses across requesters are not checked. The writes serialize in grant order and the last write wins.
- Width rules: rr_ptr and owner wrap modulo NREQ. burst_cnt is 4 bits and saturates at MAXBURST. grant_id is zero-extended to 3 bits.
- Request payload semantics:
  - Inputs are sampled only at a transfer.
  - A requester must hold valid, addr and data stable until ready.
  - Dropping valid before ready is allowed; that request is lost without a write.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0, locked=0. Release reset -> requester 0 is granted first.
2. Round-robin: req_valid=4'b1111 steady, lock=0 -> grant_id sequence 0,1,2,3,0, one write per cycle, wr_data matches the granted requester each cycle after the transfer.
3. Fixed priority: prio_fixed=1, req_valid=4'b1010 for 3 cycles -> requester 1 is granted every cycle and requester 3 never is. Then set prio_fixed=0 -> requester 3 is granted next.
4. Burst: req_valid=4'b0101, req_lock[2]=1, rr_ptr at 2, MAXBURST=4 -> requester 2 gets 4 consecutive writes with locked=1, then is forced to IDLE and requester 0 is granted next.
5. Stall: bank_stall=1 for 2 cycles mid-sequence with req_valid=4'b0110 -> req_ready=0 and wr_en=0 during the stall, rr_ptr is unchanged, and the pre-stall winner is granted after release.
6. Reset mid-burst: rst_n=0 while locked=1 with burst_cnt=2 -> next cycle locked=0, wr_en=0. After release, round-robin restarts at index 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the DFF register bank. It picks one of NREQ
// requesters each cycle, by round-robin or fixed priority, and can hold the
// grant on one requester for a locked burst of up to MAXBURST writes. All
// bank-side outputs are registered.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              prio_fixed,
  input  logic              bank_stall,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [2:0]        grant_id,
  output logic              locked
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [PW-1:0]   owner, owner_d;
  logic [3:0]      burst_cnt, cnt_d;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   rr_idx;
  logic            win_found;
  logic            xfer;

  // Winner search: owner only while locked, else lowest index or
  // first valid index at or above rr_ptr with wrap-around.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    rr_idx    = '0;
    if (state_q == ST_LOCKED) begin
      winner    = owner;
      win_found = req_valid[owner];
    end else if (prio_fixed) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!win_found && req_valid[PW'(k)]) begin
          win_found = 1'b1;
          winner    = PW'(k);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        rr_idx = PW'((32'(rr_ptr) + k) % NREQ);
        if (!win_found && req_valid[rr_idx]) begin
          win_found = 1'b1;
          winner    = rr_idx;
        end
      end
    end
  end

  // Ready strobe for the winner; a transfer is exactly ready & valid.
  always_comb begin
    req_ready = '0;
    xfer      = rst_n && !bank_stall && win_found;
    if (xfer) req_ready[winner] = 1'b1;
  end

  // Next-state logic for the lock FSM, burst counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner;
    cnt_d   = burst_cnt;
    rr_d    = rr_ptr;
    if (xfer) begin
      if (!prio_fixed) rr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
      if (state_q == ST_IDLE) begin
        // With MAXBURST=1 the first write already exhausts the burst,
        // so the lock is never entered.
        if (req_lock[winner] && (MAXBURST > 1)) begin
          state_d = ST_LOCKED;
          owner_d = winner;
          cnt_d   = 4'd1;
        end
      end else if (!req_lock[owner] || (burst_cnt + 4'd1 >= 4'(MAXBURST))) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = burst_cnt + 4'd1;
      end
    end else if ((state_q == ST_LOCKED) && !bank_stall && !req_valid[owner]) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // State registers and registered bank write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      owner     <= owner_d;
      burst_cnt <= cnt_d;
      locked    <= (state_d == ST_LOCKED);
      wr_en     <= xfer;
      if (xfer) begin
        wr_addr  <= req_addr[winner*AW +: AW];
        wr_data  <= req_data[winner*DW +: DW];
        grant_id <= 3'(winner);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario bench for regfile_wr_arbiter with a queue scoreboard fed by a
// behavioural reference model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_lock, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               prio_fixed, bank_stall;
  logic               wr_en, locked;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [2:0]         grant_id;

  int n_vec = 0;
  int n_err = 0;

  // Packed record: {ready[19:16], en[15], addr[14:12], data[11:4], id[3:1], locked[0]}
  logic [19:0] sb[$];

  // Reference model state
  logic       m_lock;
  int         m_rr, m_owner, m_cnt;
  logic       m_en;
  logic [2:0] m_addr, m_id;
  logic [7:0] m_data;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .prio_fixed(prio_fixed), .bank_stall(bank_stall), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, run model, push expectation, capture DUT.
  task automatic tick(input logic [3:0] v, input logic [3:0] lk, input logic st,
                      input logic pf, input logic rn,
                      output logic [19:0] obs, output logic [19:0] exp_v);
    logic [3:0] rdy_s, e_rdy;
    int win;
    rst_n = rn; req_valid = v; req_lock = lk; bank_stall = st; prio_fixed = pf;
    req_addr = 12'($urandom);
    req_data = 32'($urandom);
    #1;
    rdy_s = req_ready;
    e_rdy = '0;
    win = -1;
    if (!rn) begin
      m_lock = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      m_en = 0; m_addr = '0; m_data = '0; m_id = '0;
    end else begin
      if (!st) begin
        if (m_lock) begin
          if (v[m_owner]) win = m_owner;
        end else if (pf) begin
          for (int k = NREQ - 1; k >= 0; k--) if (v[k]) win = k;
        end else begin
          for (int k = 0; k < NREQ; k++)
            if (win < 0 && v[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
        end
      end
      if (win >= 0) begin
        e_rdy[win] = 1'b1;
        m_en = 1; m_addr = req_addr[win*AW +: AW]; m_data = req_data[win*DW +: DW];
        m_id = 3'(win);
        if (!pf) m_rr = (win + 1) % NREQ;
        if (!m_lock) begin
          if (lk[win]) begin m_lock = 1; m_owner = win; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (!lk[win] || m_cnt == MAXB) begin m_lock = 0; m_cnt = 0; end
        end
      end else begin
        m_en = 0;
        if (m_lock && !st && !v[m_owner]) begin m_lock = 0; m_cnt = 0; end
      end
    end
    sb.push_back({e_rdy, m_en, m_addr, m_data, m_id, m_lock});
    @(posedge clk);
    #1;
    obs = {rdy_s, wr_en, wr_addr, wr_data, grant_id, locked};
    exp_v = sb.pop_front();
  endtask

  task automatic test_reset;
    logic [19:0] o, e;
    for (int i = 0; i < 2; i++) begin
      tick(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_sb[%0d] got %h want %h", i, o, e); end
      n_vec++;
      if (o !== 20'h0) begin n_err++; $display("FAIL reset_zero[%0d] got %h want 00000", i, o); end
    end
    tick(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL reset_rel_sb got %h want %h", o, e); end
    n_vec++;
    if (o[19:16] !== 4'b0001 || o[15] !== 1'b1 || o[3:1] !== 3'd0) begin
      n_err++; $display("FAIL reset_first_grant got rdy=%b en=%b id=%0d want rdy=0001 en=1 id=0", o[19:16], o[15], o[3:1]);
    end
  endtask

  task automatic test_round_robin;
    logic [19:0] o, e;
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
    tick(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, o, e);
    for (int i = 0; i < 6; i++) begin
      tick(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL rr_sb[%0d] got %h want %h", i, o, e); end
      n_vec++;
      if (o[15] !== 1'b1 || o[3:1] !== 3'(exp_ids[i])) begin
        n_err++; $display("FAIL rr_seq[%0d] got en=%b id=%0d want en=1 id=%0d", i, o[15], o[3:1], exp_ids[i]);
      end
    end
  endtask

  task automatic test_fixed_priority;
    logic [19:0] o, e;
    for (int i = 0; i < 3; i++) begin
      tick(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL fixed_sb[%0d] got %h want %h", i, o, e); end
      n_vec++;
      if (o[3:1] !== 3'd1 || o[19:16] !== 4'b0010) begin
        n_err++; $display("FAIL fixed_win[%0d] got id=%0d rdy=%b want id=1 rdy=0010", i, o[3:1], o[19:16]);
      end
    end
    tick(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL fixed_to_rr_sb got %h want %h", o, e); end
    n_vec++;
    if (o[3:1] !== 3'd3) begin n_err++; $display("FAIL fixed_to_rr got id=%0d want 3", o[3:1]); end
  endtask

  task automatic test_burst;
    logic [19:0] o, e;
    logic exp_lk[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tick(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o[3:1] !== 3'd0) begin n_err++; $display("FAIL burst_pre got id=%0d want 0", o[3:1]); end
    for (int i = 0; i < 4; i++) begin
      tick(4'b0101, 4'b0100, 1'b0, 1'b0, 1'b1, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL burst_sb[%0d] got %h want %h", i, o, e); end
      n_vec++;
      if (o[3:1] !== 3'd2 || o[15] !== 1'b1 || o[0] !== exp_lk[i]) begin
        n_err++; $display("FAIL burst_beat[%0d] got id=%0d en=%b locked=%b want id=2 en=1 locked=%b", i, o[3:1], o[15], o[0], exp_lk[i]);
      end
    end
    tick(4'b0101, 4'b0100, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL burst_release_sb got %h want %h", o, e); end
    n_vec++;
    if (o[3:1] !== 3'd0 || o[0] !== 1'b0) begin
      n_err++; $display("FAIL burst_release got id=%0d locked=%b want id=0 locked=0", o[3:1], o[0]);
    end
  endtask

  task automatic test_stall;
    logic [19:0] o, e;
    tick(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o[3:1] !== 3'd1) begin n_err++; $display("FAIL stall_pre got id=%0d want 1", o[3:1]); end
    for (int i = 0; i < 2; i++) begin
      tick(4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL stall_sb[%0d] got %h want %h", i, o, e); end
      n_vec++;
      if (o[19:16] !== 4'b0000 || o[15] !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d] got rdy=%b en=%b want rdy=0000 en=0", i, o[19:16], o[15]);
      end
    end
    tick(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL stall_release_sb got %h want %h", o, e); end
    n_vec++;
    if (o[3:1] !== 3'd2 || o[15] !== 1'b1) begin
      n_err++; $display("FAIL stall_release got id=%0d en=%b want id=2 en=1", o[3:1], o[15]);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [19:0] o, e;
    for (int i = 0; i < 2; i++) begin
      tick(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, o, e);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL midrst_sb[%0d] got %h want %h", i, o, e); end
    end
    n_vec++;
    if (o[0] !== 1'b1) begin n_err++; $display("FAIL midrst_locked got %b want 1", o[0]); end
    tick(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, o, e);
    n_vec++;
    if (o[0] !== 1'b0 || o[15] !== 1'b0 || o[19:16] !== 4'b0000) begin
      n_err++; $display("FAIL midrst_reset got locked=%b en=%b rdy=%b want 0 0 0000", o[0], o[15], o[19:16]);
    end
    tick(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, o, e);
    n_vec++;
    if (o !== e) begin n_err++; $display("FAIL midrst_restart_sb got %h want %h", o, e); end
    n_vec++;
    if (o[3:1] !== 3'd0 || o[0] !== 1'b0) begin
      n_err++; $display("FAIL midrst_restart got id=%0d locked=%b want id=0 locked=0", o[3:1], o[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
    prio_fixed = 1'b0; bank_stall = 1'b0;
    m_lock = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
    m_en = 0; m_addr = '0; m_data = '0; m_id = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_burst();
    test_stall();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
